// File: rtl/axi_sram_responder.sv
// Single-port SRAM behind a minimal AXI4 slave: one transaction at a time,
// INCR bursts of 32-bit beats, fixed read latency, writes preferred over reads.
module axi_sram_responder #(
  parameter int MEM_SIZE   = 'h4000,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_awaddr,
  input  logic [7:0]  m_awlen,
  input  logic        m_awvalid,
  input  logic [31:0] m_araddr,
  input  logic [7:0]  m_arlen,
  input  logic        m_arvalid,
  input  logic [31:0] m_wdata,
  input  logic        m_wlast,
  input  logic        m_wvalid,
  input  logic        m_bready,
  input  logic        m_rready,
  output logic        s_awready,
  output logic        s_arready,
  output logic        s_wready,
  output logic        s_bvalid,
  output logic        s_rvalid,
  output logic [31:0] s_rdata
);
  localparam int IW = $clog2(MEM_SIZE);

  typedef enum logic [2:0] {
    IDLE, WRITE_BURST, WRITE_RESP, READ_WAIT, READ_BURST
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [8:0]    beats, beats_nxt;
  logic [3:0]    lat_cnt, lat_cnt_nxt;
  logic          mem_we;
  logic [31:0]   mem [MEM_SIZE];

  // Burst length is taken from AWLEN alone, and words wrap by index width.
  logic unused_bits;
  assign unused_bits = ^{m_wlast, m_awaddr[31:IW+2], m_awaddr[1:0],
                         m_araddr[31:IW+2], m_araddr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      beats   <= '0;
      lat_cnt <= '0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      beats   <= beats_nxt;
      lat_cnt <= lat_cnt_nxt;
    end
  end

  // Storage has no reset so an interrupted burst keeps the beats already taken.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= m_wdata;
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    beats_nxt   = beats;
    lat_cnt_nxt = lat_cnt;
    mem_we      = 1'b0;
    s_awready   = 1'b0;
    s_arready   = 1'b0;
    s_wready    = 1'b0;
    s_bvalid    = 1'b0;
    s_rvalid    = 1'b0;
    s_rdata     = '0;
    case (state)
      IDLE: begin
        s_awready = 1'b1;
        s_arready = !m_awvalid;
        if (m_awvalid) begin
          idx_nxt   = m_awaddr[IW+1:2];
          beats_nxt = {1'b0, m_awlen} + 9'd1;
          state_nxt = WRITE_BURST;
        end else if (m_arvalid) begin
          idx_nxt     = m_araddr[IW+1:2];
          beats_nxt   = {1'b0, m_arlen} + 9'd1;
          lat_cnt_nxt = 4'(RD_LATENCY);
          state_nxt   = (RD_LATENCY == 0) ? READ_BURST : READ_WAIT;
        end
      end
      WRITE_BURST: begin
        s_wready = 1'b1;
        if (m_wvalid) begin
          mem_we    = 1'b1;
          idx_nxt   = idx + 1'b1;
          beats_nxt = beats - 9'd1;
          if (beats == 9'd1) state_nxt = WRITE_RESP;
        end
      end
      WRITE_RESP: begin
        s_bvalid = 1'b1;
        if (m_bready) state_nxt = IDLE;
      end
      READ_WAIT: begin
        lat_cnt_nxt = lat_cnt - 4'd1;
        if (lat_cnt <= 4'd1) state_nxt = READ_BURST;
      end
      READ_BURST: begin
        s_rvalid = 1'b1;
        s_rdata  = mem[idx];
        if (m_rready) begin
          idx_nxt   = idx + 1'b1;
          beats_nxt = beats - 9'd1;
          if (beats == 9'd1) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Reset forces IDLE, whose readies would otherwise show through.
    if (reset) begin
      mem_we    = 1'b0;
      s_awready = 1'b0;
      s_arready = 1'b0;
      s_wready  = 1'b0;
      s_bvalid  = 1'b0;
      s_rvalid  = 1'b0;
      s_rdata   = '0;
    end
  end
endmodule
